dram_copy_engine: RTL and testbench
===================================

// Module: dram_copy_engine
// PURPOSE
// - Bus initiator for the 8-bit data RAM port (Address/MemWrite/WriteData out, read data in).
// - Copies Length bytes from SrcAddr to DstAddr, one byte per READ/WRITE cycle pair, in ascending order.
// - Sits beside the core on the data RAM port; a top-level mux gives it the port while Busy=1.
// PARAMETERS
// - AW  8  address width; also the byte-pointer width
// - DW  8  data width of the RAM word
// PORTS
// - CLK       in   1     system clock, rising edge
// - RST_N     in   1     asynchronous active-low reset
// - Start     in   1     copy request, sampled in IDLE only
// - Abort     in   1     terminate transfer, sampled in READ/WRITE
// - SrcAddr   in   AW    first source byte address, latched on accepted Start
// - DstAddr   in   AW    first destination byte address, latched on accepted Start
// - Length    in   AW+1  byte count 0..2**AW, latched on accepted Start
// - MemIn     in   DW    RAM read data; combinational from Address
// - Address   out  AW    RAM address
// - MemWrite  out  1     RAM write enable; the RAM commits on the CLK edge ending the cycle
// - WriteData out  DW    RAM write data
// - Busy      out  1     high in READ/WRITE
// - Done      out  1     one-cycle pulse in DONE state
// - Checksum  out  DW    (CHECKSUM only) mod-2**DW sum of bytes copied
// BEHAVIOUR
// - Reset: one clock, asynchronous, active-low. Asserting RST_N=0 forces state=IDLE immediately (no clock needed).
//   - Address=0, MemWrite=0, WriteData=0, Busy=0, Done=0, Checksum=0.
//   - Internal src/dst pointers and remaining count are cleared.
// - Output timing: all outputs decode registered state only; there is no input-to-output combinational path.
// - FSM state IDLE: outputs idle.
//   - Start=1 and Length!=0: latch SrcAddr, DstAddr, Length; go to READ.
//   - Start=1 and Length=0: go to DONE; no RAM access.
// - FSM state READ: Address=src, MemWrite=0.
//   - At the edge: capture MemIn into the byte buffer; go to WRITE.
// - FSM state WRITE: Address=dst, MemWrite=1, WriteData=buffer.
//   - At the edge: src+=1, dst+=1, cnt-=1.
//   - If cnt becomes 0, go to DONE; otherwise go to READ.
// - FSM state DONE: Done=1 for exactly one cycle, then IDLE.
// - Latency: Start accepted at edge E leads to Done high in cycle 2*Length+1 after E. Throughput is 2 cycles per byte.
// - Start handling: Start is ignored while not in IDLE; it is not queued. Start in the DONE cycle is also ignored.
// - Abort:
//   - In READ: next state DONE; no write occurs.
//   - In WRITE: the current write still commits at that edge; then DONE.
//   - Abort in IDLE/DONE has no effect.
// - Pointer wrap: pointers wrap modulo 2**AW (src=0xFF is followed by 0x00).
// - Length: 2**AW (256) copies the whole memory.
// - Overlap: no special handling; semantics are strictly ascending byte-by-byte. Overlapping dst>src replicates source bytes.
// - Reset mid-transfer: bytes already written stay written; no Done pulse is generated.
// CONFIGURATION
// - Macro DRAM_COPY_CHECKSUM_EN.
//   - Defined: Checksum port exists. It clears on each accepted Start and adds each buffer byte on every committed WRITE (mod 2**DW).
//   - Checksum holds its value after DONE until the next accepted Start.
//   - Undefined: port and logic are absent; all other behaviour is identical.
// STRUCTURE
// - Package dram_copy_pkg holds:
//   - typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} copy_state_t;
//   - localparams for the default AW/DW.
// - Sub-module dram_copy_csum is the checksum accumulator (clr, add_en, byte in, sum out). It is instantiated only under DRAM_COPY_CHECKSUM_EN.
// TESTING
// - Bench: behavioural RAM model with combinational read and posedge write, preloaded M[i]=i.
// - Src=0x10, Dst=0x80, Len=4:
//   - M[0x80..0x83]=0x10..0x13.
//   - Busy high for 8 cycles; Done pulses once in the 9th cycle after Start.
// - Len=0:
//   - Done pulses the cycle after Start.
//   - MemWrite is never asserted; Busy stays 0.
// - Src=0xFE, Dst=0x40, Len=3:
//   - Reads 0xFE, 0xFF, 0x00; M[0x40..0x42]=0xFE, 0xFF, 0x00 (pointer wrap).
// - Abort during the 2nd WRITE of a Len=5 copy:
//   - Exactly 2 bytes written; Done pulses the next cycle.
//   - A Start arriving while Busy is ignored.
// - RST_N low mid-transfer:
//   - MemWrite/Busy drop without a clock edge.
//   - No Done pulse; a new Start after reset completes normally.
//   - With the macro defined, Len=4 from 0x10 gives Checksum=0x46.

Source files
------------

// File: rtl/dram_copy_pkg.sv
// Shared types and default widths for the data-RAM copy engine.
package dram_copy_pkg;

    localparam int unsigned DEF_AW = 8;
    localparam int unsigned DEF_DW = 8;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} copy_state_t;

endpackage

// File: rtl/dram_copy_csum.sv
// Running mod-2**DW sum of the bytes committed by the copy engine.
module dram_copy_csum #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          add_en,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] sum
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= sum + data;
        end
    end

endmodule

// File: rtl/dram_copy_engine.sv
// Byte-wise RAM-to-RAM copy initiator (READ/WRITE cycle pairs, ascending addresses).
// Optional checksum output enabled by defining DRAM_COPY_CHECKSUM_EN.
module dram_copy_engine
    import dram_copy_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          Start,
    input  logic          Abort,
    input  logic [AW-1:0] SrcAddr,
    input  logic [AW-1:0] DstAddr,
    input  logic [AW:0]   Length,
    input  logic [DW-1:0] MemIn,
    output logic [AW-1:0] Address,
    output logic          MemWrite,
    output logic [DW-1:0] WriteData,
    output logic          Busy,
    output logic          Done
`ifdef DRAM_COPY_CHECKSUM_EN
    ,
    output logic [DW-1:0] Checksum
`endif
);

    copy_state_t   state, state_d;
    logic [AW-1:0] src, src_d;
    logic [AW-1:0] dst, dst_d;
    logic [AW:0]   cnt, cnt_d;
    logic [DW-1:0] byte_buf, byte_buf_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            src      <= '0;
            dst      <= '0;
            cnt      <= '0;
            byte_buf <= '0;
        end else begin
            state    <= state_d;
            src      <= src_d;
            dst      <= dst_d;
            cnt      <= cnt_d;
            byte_buf <= byte_buf_d;
        end
    end

    always_comb begin
        state_d    = state;
        src_d      = src;
        dst_d      = dst;
        cnt_d      = cnt;
        byte_buf_d = byte_buf;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (Length != '0) begin
                        src_d   = SrcAddr;
                        dst_d   = DstAddr;
                        cnt_d   = Length;
                        state_d = READ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            READ: begin
                byte_buf_d = MemIn;
                state_d    = Abort ? DONE : WRITE;
            end
            WRITE: begin
                // The write commits at this edge even when aborting.
                src_d = src + 1'b1;
                dst_d = dst + 1'b1;
                cnt_d = cnt - 1'b1;
                if (Abort || cnt == (AW+1)'(1)) begin
                    state_d = DONE;
                end else begin
                    state_d = READ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Address   = '0;
        MemWrite  = 1'b0;
        WriteData = '0;
        case (state)
            READ:  Address = src;
            WRITE: begin
                Address   = dst;
                MemWrite  = 1'b1;
                WriteData = byte_buf;
            end
            default: ;
        endcase
    end

    assign Busy = (state == READ) || (state == WRITE);
    assign Done = (state == DONE);

`ifdef DRAM_COPY_CHECKSUM_EN
    logic csum_clr;
    logic csum_add;

    assign csum_clr = (state == IDLE) && Start;
    assign csum_add = (state == WRITE);

    dram_copy_csum #(
        .DW(DW)
    ) u_csum (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (csum_clr),
        .add_en(csum_add),
        .data  (byte_buf),
        .sum   (Checksum)
    );
`endif

endmodule

// File: tb/tb_dram_copy_engine.sv
// Self-checking bench: table of copy jobs against a RAM model plus a write scoreboard.
module tb_dram_copy_engine;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       Start = 1'b0;
    logic       Abort = 1'b0;
    logic [7:0] SrcAddr = '0;
    logic [7:0] DstAddr = '0;
    logic [8:0] Length = '0;
    logic [7:0] MemIn;
    logic [7:0] Address;
    logic       MemWrite;
    logic [7:0] WriteData;
    logic       Busy;
    logic       Done;
`ifdef DRAM_COPY_CHECKSUM_EN
    logic [7:0] Checksum;
`endif

    logic [7:0] mem [256];
    logic       reload = 1'b1;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    dram_copy_engine dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .Start    (Start),
        .Abort    (Abort),
        .SrcAddr  (SrcAddr),
        .DstAddr  (DstAddr),
        .Length   (Length),
        .MemIn    (MemIn),
        .Address  (Address),
        .MemWrite (MemWrite),
        .WriteData(WriteData),
        .Busy     (Busy),
        .Done     (Done)
`ifdef DRAM_COPY_CHECKSUM_EN
        ,
        .Checksum (Checksum)
`endif
    );

    assign MemIn = mem[Address];

    always @(posedge CLK) begin
        if (reload) begin
            for (int i = 0; i < 256; i++) mem[i] <= i[7:0];
        end else if (MemWrite) begin
            mem[Address] <= WriteData;
        end
    end

    typedef struct {
        logic [7:0] src;
        logic [7:0] dst;
        logic [8:0] len;
        int         abort_k;
        bit         glitch;
        int         exp_done;
        int         exp_busy;
    } vec_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t  exp_q[$];
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reload();
        @(negedge CLK);
        reload = 1'b1;
        @(negedge CLK);
        reload = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] mm [256];
        int n, done_cyc, busy_cyc, wcount, sum, bad;
        logic [7:0] a, d;
        wr_t w;
        do_reload();
        for (int i = 0; i < 256; i++) mm[i] = i[7:0];
        n = (v.abort_k != 0) ? v.abort_k : int'(v.len);
        sum = 0;
        for (int i = 0; i < n; i++) begin
            a = v.dst + i[7:0];
            d = mm[v.src + i[7:0]];
            mm[a] = d;
            exp_q.push_back({a, d});
            sum += int'(d);
        end
        SrcAddr = v.src;
        DstAddr = v.dst;
        Length  = v.len;
        Start   = 1'b1;
        @(posedge CLK);
        #1 Start = 1'b0;
        done_cyc = -1;
        busy_cyc = 0;
        wcount   = 0;
        for (int c = 1; c <= 600; c++) begin
            @(negedge CLK);
            Abort = 1'b0;
            Start = 1'b0;
            if (v.glitch && c == 1) begin
                Start   = 1'b1;
                Length  = 9'd0;
                SrcAddr = 8'hEE;
            end
            if (MemWrite) begin
                wcount++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {16'd0, Address, WriteData}, 32'd0);
                end else begin
                    w = exp_q.pop_front();
                    chk("write_addr", {24'd0, Address}, {24'd0, w.a});
                    chk("write_data", {24'd0, WriteData}, {24'd0, w.d});
                end
                if (wcount == v.abort_k) Abort = 1'b1;
            end
            if (Busy) busy_cyc++;
            if (Done) begin
                done_cyc = c;
                break;
            end
        end
        Abort = 1'b0;
        Start = 1'b0;
        chk("done_cycle", done_cyc, v.exp_done);
        chk("busy_cycles", busy_cyc, v.exp_busy);
        chk("writes_left", exp_q.size(), 0);
        exp_q.delete();
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== mm[i]) bad++;
        chk("mem_contents_bad", bad, 0);
`ifdef DRAM_COPY_CHECKSUM_EN
        chk("checksum", {24'd0, Checksum}, sum & 32'hFF);
`endif
        @(negedge CLK);
        chk("done_single_pulse", {30'd0, Done, Busy}, 32'd0);
    endtask

    initial begin
        int dcount;
        //         src    dst    len     abort glitch done busy
        vecs[0] = '{8'h10, 8'h80, 9'd4,   0, 1'b0, 9,   8};
        vecs[1] = '{8'h10, 8'h80, 9'd0,   0, 1'b0, 1,   0};
        vecs[2] = '{8'hFE, 8'h40, 9'd3,   0, 1'b0, 7,   6};
        vecs[3] = '{8'h20, 8'h60, 9'd5,   2, 1'b1, 5,   4};
        vecs[4] = '{8'h10, 8'h11, 9'd4,   0, 1'b0, 9,   8};
        vecs[5] = '{8'h10, 8'h90, 9'd256, 0, 1'b0, 513, 512};

        #3;
        chk("rst_address", {24'd0, Address}, 32'd0);
        chk("rst_ctrl", {29'd0, MemWrite, Busy, Done}, 32'd0);
        chk("rst_wdata", {24'd0, WriteData}, 32'd0);
`ifdef DRAM_COPY_CHECKSUM_EN
        chk("rst_checksum", {24'd0, Checksum}, 32'd0);
`endif
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset in the middle of the second WRITE of a 5-byte copy.
        do_reload();
        SrcAddr = 8'h10;
        DstAddr = 8'h80;
        Length  = 9'd5;
        Start   = 1'b1;
        @(posedge CLK);
        #1 Start = 1'b0;
        repeat (4) @(negedge CLK);
        chk("mid_write_active", {31'd0, MemWrite}, 32'd1);
        #2 RST_N = 1'b0;
        #1;
        chk("async_rst_ctrl", {29'd0, MemWrite, Busy, Done}, 32'd0);
        chk("async_rst_addr", {24'd0, Address}, 32'd0);
        dcount = 0;
        repeat (3) begin
            @(negedge CLK);
            if (Done) dcount++;
        end
        RST_N = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            if (Done) dcount++;
        end
        chk("no_done_after_rst", dcount, 0);
        chk("rst_kept_byte0", {24'd0, mem[8'h80]}, 32'h10);
        chk("rst_unwritten_byte", {24'd0, mem[8'h82]}, 32'h82);

        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
